// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN kernel-loading path: scheduler FSM state
// encoding, default channel/kernel counts and a width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_N_CHANNELS = 3;
    localparam int CNN_N_KERNELS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // $clog2 that never returns 0, so single-entry fields keep one bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/kernel_load_watchdog.sv
// -----------------------------------------------------------------------------
// kernel_load_watchdog
// Stall counter for the LOAD phase. Clears on clear_i, otherwise counts on
// inc_i. expired_o is combinational and flags the cycle in which the count
// would reach STALL_LIMIT.
// Ports:
//   clock_i    in   system clock
//   reset_i    in   asynchronous active-high reset
//   clear_i    in   force count to zero (has priority over inc_i)
//   inc_i      in   advance count by one
//   expired_o  out  count reaches STALL_LIMIT on this edge
// -----------------------------------------------------------------------------
module kernel_load_watchdog
    import cnn_pkg::*;
#(
    parameter int STALL_LIMIT = 1024
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int            CW   = clog2_min1(STALL_LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(STALL_LIMIT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (inc_i) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Expire as the increment that would land on STALL_LIMIT is taken, so
    // the registered error appears exactly STALL_LIMIT idle cycles in.
    assign expired_o = inc_i && (r_count == LAST);

endmodule

// File: rtl/kernel_load_scheduler.sv
// -----------------------------------------------------------------------------
// kernel_load_scheduler
// Sequences kernel_buffer channels for each of N_KERNELS kernel sets: holds
// channels in order 0..N_CHANNELS-1 as their kernel_valid arrives, presents
// the complete set to the consumer, and advances on conv_done_i. A watchdog
// aborts a LOAD that waits too long for the current channel.
// Ports:
//   clock_i          in   system clock
//   reset_i          in   asynchronous active-high reset
//   start_i          in   start a run (sampled in IDLE only)
//   kernel_valid_i   in   per-channel kernel valid from kernel_buffer
//   conv_done_i      in   consumer finished with current set (READY only)
//   buffer_enable_o  out  kernel_buffer enable
//   hold_kernel_o    out  per-channel hold to kernel_buffer
//   kernel_index_o   out  kernel set being loaded/used
//   kernels_ready_o  out  all channels held, set valid for consumer
//   busy_o           out  not in IDLE
//   done_o           out  one-cycle pulse after the last set is consumed
//   stall_error_o    out  sticky watchdog error
// All outputs are registered from the next-state values.
// -----------------------------------------------------------------------------
module kernel_load_scheduler
    import cnn_pkg::*;
#(
    parameter int N_CHANNELS  = CNN_N_CHANNELS,
    parameter int N_KERNELS   = CNN_N_KERNELS,
    parameter int STALL_LIMIT = 1024
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                start_i,
    input  logic [N_CHANNELS-1:0]               kernel_valid_i,
    input  logic                                conv_done_i,
    output logic                                buffer_enable_o,
    output logic [N_CHANNELS-1:0]               hold_kernel_o,
    output logic [clog2_min1(N_KERNELS)-1:0]    kernel_index_o,
    output logic                                kernels_ready_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                stall_error_o
);

    localparam int            PW      = clog2_min1(N_CHANNELS);
    localparam int            KW      = clog2_min1(N_KERNELS);
    localparam logic [PW-1:0] LAST_CH = PW'(N_CHANNELS - 1);
    localparam logic [KW-1:0] LAST_K  = KW'(N_KERNELS - 1);

    sched_state_t          r_state, w_state_nxt;
    logic [PW-1:0]         r_ptr, w_ptr_nxt;
    logic [N_CHANNELS-1:0] r_hold, w_hold_nxt;
    logic [KW-1:0]         r_index, w_index_nxt;
    logic                  r_ben, w_ben_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;

    logic                  w_accept;
    logic                  w_inc;
    logic                  w_expired;

    // Only the channel under the pointer can be accepted.
    assign w_accept = (r_state == ST_LOAD) && kernel_valid_i[r_ptr];
    // Count idle LOAD cycles; anything else (entry, accept, other states)
    // returns the counter to zero.
    assign w_inc    = (r_state == ST_LOAD) && !w_accept;

    kernel_load_watchdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_watchdog (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .clear_i   (!w_inc),
        .inc_i     (w_inc),
        .expired_o (w_expired)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_index <= '0;
            r_ben   <= 1'b0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_index <= w_index_nxt;
            r_ben   <= w_ben_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_index_nxt = r_index;
        w_ben_nxt   = r_ben;
        w_ready_nxt = r_ready;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_LOAD;
                    w_ptr_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_index_nxt = '0;
                    w_ben_nxt   = 1'b1;
                    w_ready_nxt = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_hold_nxt[r_ptr] = 1'b1;
                    if (r_ptr == LAST_CH) begin
                        w_state_nxt = ST_READY;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + PW'(1);
                    end
                end else if (w_expired) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_ben_nxt   = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_READY: begin
                if (conv_done_i) begin
                    w_hold_nxt  = '0;
                    w_ready_nxt = 1'b0;
                    w_ptr_nxt   = '0;
                    if (r_index < LAST_K) begin
                        w_state_nxt = ST_NEXT;
                        w_index_nxt = r_index + KW'(1);
                    end else begin
                        w_state_nxt = ST_DONE;
                        w_ben_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                w_state_nxt = ST_LOAD;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign buffer_enable_o = r_ben;
    assign hold_kernel_o   = r_hold;
    assign kernel_index_o  = r_index;
    assign kernels_ready_o = r_ready;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign stall_error_o   = r_err;

endmodule

// File: tb/tb_kernel_load_scheduler.sv
// -----------------------------------------------------------------------------
// tb_kernel_load_scheduler
// Three scheduler instances share clock and reset: A (defaults), B
// (STALL_LIMIT=8) and C (N_KERNELS=1). Expected kernel indices of READY
// windows are queued as runs are started and popped when ready rises.
// -----------------------------------------------------------------------------
module tb_kernel_load_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults
    logic       a_start = 1'b0, a_conv = 1'b0;
    logic [2:0] a_valid = '0;
    logic       a_ben, a_rdy, a_busy, a_done, a_err;
    logic [2:0] a_hold;
    logic [1:0] a_idx;

    // Instance B: STALL_LIMIT = 8
    logic       b_start = 1'b0, b_conv = 1'b0;
    logic [2:0] b_valid = '0;
    logic       b_ben, b_rdy, b_busy, b_done, b_err;
    logic [2:0] b_hold;
    logic [1:0] b_idx;

    // Instance C: N_KERNELS = 1
    logic       c_start = 1'b0, c_conv = 1'b0;
    logic [2:0] c_valid = '0;
    logic       c_ben, c_rdy, c_busy, c_done, c_err;
    logic [2:0] c_hold;
    logic [0:0] c_idx;

    kernel_load_scheduler u_dut_a (
        .clock_i(clk), .reset_i(rst), .start_i(a_start), .kernel_valid_i(a_valid),
        .conv_done_i(a_conv), .buffer_enable_o(a_ben), .hold_kernel_o(a_hold),
        .kernel_index_o(a_idx), .kernels_ready_o(a_rdy), .busy_o(a_busy),
        .done_o(a_done), .stall_error_o(a_err)
    );

    kernel_load_scheduler #(.STALL_LIMIT(8)) u_dut_b (
        .clock_i(clk), .reset_i(rst), .start_i(b_start), .kernel_valid_i(b_valid),
        .conv_done_i(b_conv), .buffer_enable_o(b_ben), .hold_kernel_o(b_hold),
        .kernel_index_o(b_idx), .kernels_ready_o(b_rdy), .busy_o(b_busy),
        .done_o(b_done), .stall_error_o(b_err)
    );

    kernel_load_scheduler #(.N_KERNELS(1)) u_dut_c (
        .clock_i(clk), .reset_i(rst), .start_i(c_start), .kernel_valid_i(c_valid),
        .conv_done_i(c_conv), .buffer_enable_o(c_ben), .hold_kernel_o(c_hold),
        .kernel_index_o(c_idx), .kernels_ready_o(c_rdy), .busy_o(c_busy),
        .done_o(c_done), .stall_error_o(c_err)
    );

    int checks = 0;
    int errors = 0;
    int q_a[$];
    int q_c[$];
    int a_done_cnt = 0;
    logic a_rdy_q = 1'b0;
    logic c_rdy_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input logic ben, input logic [2:0] hold,
                            input logic [1:0] idx, input logic rdy, input logic busy,
                            input logic done, input logic err);
        check({tag, "_ben"},  32'(a_ben),  32'(ben));
        check({tag, "_hold"}, 32'(a_hold), 32'(hold));
        check({tag, "_idx"},  32'(a_idx),  32'(idx));
        check({tag, "_rdy"},  32'(a_rdy),  32'(rdy));
        check({tag, "_busy"}, 32'(a_busy), 32'(busy));
        check({tag, "_done"}, 32'(a_done), 32'(done));
        check({tag, "_err"},  32'(a_err),  32'(err));
    endtask

    task automatic wait_rdy_a(input int max_cycles);
        int n = 0;
        while (!a_rdy && n < max_cycles) begin
            step();
            n++;
        end
        if (!a_rdy) check("a_ready_timeout", 32'(a_rdy), 32'd1);
    endtask

    // Scoreboard: each rising kernels_ready must match the next queued index.
    always @(negedge clk) begin
        if (a_rdy && !a_rdy_q) begin
            if (q_a.size() == 0) check("a_ready_unexpected", 32'd1, 32'd0);
            else                 check("a_window_idx", 32'(a_idx), 32'(q_a.pop_front()));
        end
        if (c_rdy && !c_rdy_q) begin
            if (q_c.size() == 0) check("c_ready_unexpected", 32'd1, 32'd0);
            else                 check("c_window_idx", 32'(c_idx), 32'(q_c.pop_front()));
        end
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        a_rdy_q <= a_rdy;
        c_rdy_q <= c_rdy;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state of all instances
        repeat (2) step();
        expect_a("rst_a", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_b", 32'({b_ben, b_hold, b_idx, b_rdy, b_busy, b_done, b_err}), 32'd0);
        check("rst_c", 32'({c_ben, c_hold, c_idx, c_rdy, c_busy, c_done, c_err}), 32'd0);
        rst = 1'b0;

        // Full run on defaults: valid always high, conv_done 2 cycles after ready
        q_a.push_back(0); q_a.push_back(1); q_a.push_back(2);
        a_valid = 3'b111;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        expect_a("start", 1'b1, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("lat1_hold", 32'(a_hold), 32'b001);
        step();
        check("lat2_hold", 32'(a_hold), 32'b011);
        check("lat2_rdy", 32'(a_rdy), 32'd0);
        step();
        expect_a("lat3", 1'b1, 3'b111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_rdy_a(12);
            step(); step();
            expect_a("window", 1'b1, 3'b111, 2'(k), 1'b1, 1'b1, 1'b0, 1'b0);
            a_conv = 1'b1;
            step();
            a_conv = 1'b0;
            if (k < 2) begin
                expect_a("next", 1'b1, 3'b000, 2'(k + 1), 1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                check("done_pulse", 32'(a_done), 32'd1);
                check("done_ben", 32'(a_ben), 32'd0);
                check("done_hold", 32'(a_hold), 32'd0);
                check("done_rdy", 32'(a_rdy), 32'd0);
                check("done_busy", 32'(a_busy), 32'd1);
            end
        end
        step();
        check("idle_busy", 32'(a_busy), 32'd0);
        check("idle_done", 32'(a_done), 32'd0);
        check("done_count", 32'(a_done_cnt), 32'd1);

        // Out-of-order valid: only the pointer channel is accepted
        q_a.push_back(0);
        a_valid = 3'b000;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        expect_a("ooo_start", 1'b1, 3'b000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        a_valid = 3'b100; step(); check("ooo_ch2_early", 32'(a_hold), 32'b000);
        a_valid = 3'b001; step(); check("ooo_ch0", 32'(a_hold), 32'b001);
        a_valid = 3'b100; step(); check("ooo_ch2_early2", 32'(a_hold), 32'b001);
        a_valid = 3'b010; step(); check("ooo_ch1", 32'(a_hold), 32'b011);
        a_valid = 3'b100; step();
        expect_a("ooo_ready", 1'b1, 3'b111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        a_valid = 3'b000;

        // start in READY and conv_done in LOAD are ignored
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        expect_a("ign_start", 1'b1, 3'b111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        a_conv = 1'b1;
        step();
        a_conv = 1'b0;
        expect_a("ign_next", 1'b1, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        a_conv = 1'b1;
        a_start = 1'b1;
        step();
        a_conv = 1'b0;
        a_start = 1'b0;
        expect_a("ign_conv", 1'b1, 3'b000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);
        a_valid = 3'b001;
        step();
        a_valid = 3'b000;
        expect_a("ign_ptr", 1'b1, 3'b001, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-LOAD, observed before the next edge
        #3;
        rst = 1'b1;
        #1;
        expect_a("async_rst", 1'b0, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        check("first_start_busy", 32'(a_busy), 32'd1);
        check("first_start_ben", 32'(a_ben), 32'd1);

        // Watchdog: valid held low from LOAD entry
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("stall_entry_busy", 32'(b_busy), 32'd1);
        for (int i = 1; i < 8; i++) begin
            step();
            check("stall_early_err", 32'(b_err), 32'd0);
            check("stall_early_busy", 32'(b_busy), 32'd1);
        end
        step();
        check("stall_err", 32'(b_err), 32'd1);
        check("stall_busy", 32'(b_busy), 32'd0);
        check("stall_hold", 32'(b_hold), 32'd0);
        check("stall_rdy", 32'(b_rdy), 32'd0);
        step();
        check("stall_sticky", 32'(b_err), 32'd1);

        // New start clears the error; an accepted valid restarts the count
        b_valid = 3'b001;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        check("stall_clear_err", 32'(b_err), 32'd0);
        check("stall_clear_busy", 32'(b_busy), 32'd1);
        step();
        b_valid = 3'b000;
        check("stall2_hold", 32'(b_hold), 32'b001);
        for (int i = 1; i < 8; i++) begin
            step();
            check("stall2_early_err", 32'(b_err), 32'd0);
        end
        step();
        check("stall2_err", 32'(b_err), 32'd1);
        check("stall2_hold_rel", 32'(b_hold), 32'd0);
        check("stall2_busy", 32'(b_busy), 32'd0);

        // Single kernel set
        q_c.push_back(0);
        c_valid = 3'b111;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        repeat (3) step();
        check("k1_rdy", 32'(c_rdy), 32'd1);
        check("k1_hold", 32'(c_hold), 32'b111);
        step(); step();
        c_conv = 1'b1;
        step();
        c_conv = 1'b0;
        check("k1_done", 32'(c_done), 32'd1);
        check("k1_idx", 32'(c_idx), 32'd0);
        check("k1_rdy_off", 32'(c_rdy), 32'd0);
        check("k1_hold_off", 32'(c_hold), 32'd0);
        check("k1_ben_off", 32'(c_ben), 32'd0);
        step();
        check("k1_done_end", 32'(c_done), 32'd0);
        check("k1_busy_end", 32'(c_busy), 32'd0);
        check("k1_idx_end", 32'(c_idx), 32'd0);

        check("a_queue_empty", 32'(q_a.size()), 32'd0);
        check("c_queue_empty", 32'(q_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_load_scheduler.md
KERNEL_LOAD_SCHEDULER -- requirements
Module: kernel_load_scheduler

Interface
REQ-001 Parameter N_CHANNELS, default 3, number of kernel_buffer channels sequenced.
REQ-002 Parameter N_KERNELS, default 3, number of kernel sets (output filters) loaded per run.
REQ-003 Parameter STALL_LIMIT, default 1024, cycles allowed in LOAD without kernel_valid_i on the current channel.
REQ-004 clock_i  in  1  single system clock; all logic on the rising edge.
REQ-005 reset_i  in  1  asynchronous, active-high reset.
REQ-006 start_i  in  1  single-cycle request to begin a run; sampled in IDLE only.
REQ-007 kernel_valid_i  in  N_CHANNELS  per-channel kernel_valid from kernel_buffer.
REQ-008 conv_done_i  in  1  consumer has finished with the current kernel set.
REQ-009 buffer_enable_o  out  1  kernel_buffer enable.
REQ-010 hold_kernel_o  out  N_CHANNELS  per-channel hold to kernel_buffer.
REQ-011 kernel_index_o  out  $clog2(N_KERNELS) (min 1)  index of kernel set being loaded/used.
REQ-012 kernels_ready_o  out  1  all channels held; kernel set valid for the consumer.
REQ-013 busy_o  out  1  high in any state other than IDLE.
REQ-014 done_o  out  1  one-cycle pulse when the last kernel set is consumed.
REQ-015 stall_error_o  out  1  sticky; STALL_LIMIT exceeded.

Function
REQ-016 FSM states IDLE, LOAD, READY, NEXT, DONE; all outputs registered.
REQ-017 IDLE: start_i=1 -> LOAD next cycle, kernel_index_o=0, channel pointer=0, buffer_enable_o=1, hold_kernel_o=0.
REQ-018 LOAD: kernel_valid_i[pointer]=1 -> hold_kernel_o[pointer] set next cycle, pointer+1; valid on other channels ignored.
REQ-019 LOAD: valid on pointer=N_CHANNELS-1 -> READY next cycle, hold_kernel_o all ones.
REQ-020 READY: kernels_ready_o=1; holds kept; conv_done_i=1 -> NEXT if kernel_index_o<N_KERNELS-1, else DONE.
REQ-021 NEXT (one cycle): hold_kernel_o=0, kernel_index_o+1, pointer=0, then LOAD.
REQ-022 DONE (one cycle): done_o=1, buffer_enable_o=0, hold_kernel_o=0, kernels_ready_o=0, then IDLE.
REQ-023 start_i outside IDLE, conv_done_i outside READY: ignored, no side effects.
REQ-024 Stall counter clears on every LOAD entry and every accepted valid; increments each LOAD cycle otherwise.
REQ-025 Counter reaching STALL_LIMIT: stall_error_o=1, FSM -> IDLE with all holds released; stall_error_o cleared only by reset or accepted start_i.
REQ-026 Load-to-ready latency with valid always high: N_CHANNELS cycles after LOAD entry.
REQ-027 N_KERNELS=1: first conv_done_i in READY -> DONE directly; kernel_index_o stays 0.

Reset
REQ-028 reset_i=1 at any time, including mid-LOAD/READY: state IDLE, pointer 0, counter 0; all outputs 0 (buffer_enable_o, hold_kernel_o, kernel_index_o, kernels_ready_o, busy_o, done_o, stall_error_o).
REQ-029 First start_i after reset deassertion is accepted on the first rising edge.

Structure
REQ-030 Shared package cnn_pkg holds the FSM state enum and default N_CHANNELS/N_KERNELS constants.
REQ-031 One sub-module, kernel_load_watchdog: clear/increment counter with STALL_LIMIT compare and expired output.
REQ-032 No memory instantiation; address generation remains inside kernel_buffer.

Verification
REQ-033 Defaults, valid all high, start pulse, conv_done 2 cycles after each ready -> three READY windows, kernel_index_o 0,1,2, done_o one pulse, busy_o low afterwards.
REQ-034 Valid asserted channel 2 then 0 then 1 -> hold sets only in order 0,1,2; channel 2 early valid ignored.
REQ-035 STALL_LIMIT=8, valid held low -> stall_error_o high 8 cycles after LOAD entry, FSM IDLE, holds 0; next start clears error.
REQ-036 reset_i asserted mid-LOAD with hold_kernel_o=3'b001 -> all outputs 0 asynchronously, before next clock edge.
REQ-037 start_i in READY and conv_done_i in LOAD -> no state, index or hold change.
REQ-038 N_KERNELS=1 -> single READY, done_o on cycle after conv_done_i, kernel_index_o stays 0.
